vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have ports: clk  in  1  system clock; all logic on its rising edge.
REQ-002 The block SHALL have ports: reset_n  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have ports: vdg_req  in  1  one-cycle pulse requesting a video fetch; vdg_addr  in  13  fetch address.
REQ-004 The block SHALL have ports: vdg_data  out  8  fetched byte; vdg_valid  out  1  one-cycle pulse, vdg_data valid.
REQ-005 The block SHALL have ports: cpu_req  in  1  CPU access request, level, held until ack; cpu_we  in  1  1 = write; cpu_addr  in  13; cpu_wdata  in  8.
REQ-006 The block SHALL have ports: cpu_rdata  out  8  read data; cpu_ack  out  1  one-cycle completion pulse.
REQ-007 The block SHALL have ports: ram_addr  out  13; ram_we  out  1; ram_din  out  8; ram_dout  in  8, from a single-port synchronous RAM with 1-clock read latency.
REQ-008 The block SHALL have ports: vdg_overrun  out  1  sticky flag, fetch request lost.

Function
REQ-009 The block SHALL share one RAM port between the VDG fetch path and the CPU; only one access is in flight at any time.
REQ-010 The FSM SHALL have states IDLE, VRD, VCAP, CRD, CCAP, CWR; all RAM outputs are registered.
REQ-011 A sampled vdg_req SHALL set vdg_pend and latch vdg_addr into vdg_addr_q; a pending fetch is served from IDLE in preference to the CPU (strict VDG priority, REQ-024).
REQ-012 VDG read SHALL be: IDLE->VRD (ram_addr=vdg_addr_q, ram_we=0)->VCAP (wait)->IDLE, loading vdg_data from ram_dout and pulsing vdg_valid; uncontended latency is 2 clocks from the edge sampling vdg_req to the vdg_valid pulse. In the same cycle, vdg_req shall go straight to VRD (bypassing vdg_pend).
REQ-013 CPU read SHALL be: IDLE->CRD->CCAP->IDLE, loading cpu_rdata and pulsing cpu_ack; uncontended latency is 2 clocks.
REQ-014 CPU write SHALL be: IDLE->CWR, driving ram_addr=cpu_addr, ram_din=cpu_wdata, ram_we=1 for exactly one clock, then IDLE with cpu_ack pulsed; latency is 1 clock.
REQ-015 cpu_req SHALL be ignored in the cycle cpu_ack is high; a new CPU request is recognised from the following cycle, preventing double service.
REQ-016 A vdg_req arriving while vdg_pend is already set and unserved SHALL overwrite vdg_addr_q (latest wins) and set vdg_overrun.
REQ-017 A vdg_req arriving while a VDG access is in VRD/VCAP SHALL set vdg_pend for a follow-up fetch without setting vdg_overrun.
REQ-018 When vdg_req and cpu_req arrive in the same IDLE cycle, the VDG SHALL be served first; the CPU starts on the next IDLE (REQ-024).
REQ-019 ram_we SHALL be 0 in every state except CWR; ram_din SHALL hold its last value outside CWR.
REQ-020 vdg_valid and cpu_ack SHALL never be high for more than one consecutive cycle each.

Reset
REQ-021 With reset_n low at a clock edge, the block SHALL enter IDLE, clear vdg_pend, vdg_overrun, vdg_valid, cpu_ack, ram_we, and zero vdg_data, cpu_rdata, ram_addr, ram_din.
REQ-022 Reset mid-operation SHALL abort the access with no ack or valid pulse; a write in CWR is cut off at the reset edge.
REQ-023 vdg_overrun SHALL clear only on reset.

Configuration
REQ-024 Macro VRAM_CPU_FAIR_EN: when defined, after any VDG access completes with cpu_req pending, the CPU SHALL be granted next even if vdg_pend is set, bounding CPU wait to one VDG access; when undefined, strict VDG priority applies and the CPU waits until vdg_pend is clear.

Verification
REQ-025 Idle, vdg_req with addr 0x0123, RAM[0x0123]=0x5A -> vdg_valid 2 clocks later, vdg_data=0x5A, no cpu_ack.
REQ-026 CPU write 0x1FFF<-0xA5 then read 0x1FFF -> ram_we one clock, ack after 1 clock; read ack after 2 clocks, cpu_rdata=0xA5.
REQ-027 vdg_req and cpu_req (read 0x0010) in the same cycle -> vdg_valid at +2, cpu_ack at +5, one access per RAM slot.
REQ-028 Two vdg_req pulses during a 2-clock CPU read, addrs 0x0100 then 0x0200 -> one fetch of 0x0200, vdg_overrun=1 and stays 1 until reset_n low.
REQ-029 Continuous vdg_req every 2 clocks plus held cpu_req -> with VRAM_CPU_FAIR_EN cpu_ack within 5 clocks; without it no cpu_ack until the stream stops.
REQ-030 reset_n low during CWR and CCAP -> no cpu_ack, all outputs at reset values on the next clock.

Source files
------------

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between VDG fetch path and CPU
// Optional macro VRAM_CPU_FAIR_EN: CPU is granted after each VDG access it waited behind.
module vram_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vdg_req,
  input  logic [12:0] vdg_addr,
  output logic [7:0]  vdg_data,
  output logic        vdg_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        vdg_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VRD,
    S_VCAP,
    S_CRD,
    S_CCAP,
    S_CWR
  } state_t;

  state_t      state_q;
  logic        vdg_pend_q;
  logic [12:0] vdg_addr_q;
  logic [7:0]  vdg_data_q;
  logic        vdg_valid_q;
  logic [7:0]  cpu_rdata_q;
  logic        cpu_ack_q;
  logic [12:0] ram_addr_q;
  logic        ram_we_q;
  logic [7:0]  ram_din_q;
  logic        vdg_overrun_q;

  logic cpu_go;
  logic cpu_first;
  logic cpu_start;
  logic vdg_bypass;

  // A request seen during the ack cycle is the one just served, not a new one.
  assign cpu_go = cpu_req && !cpu_ack_q;

`ifdef VRAM_CPU_FAIR_EN
  logic cpu_turn_q;
  assign cpu_first = cpu_turn_q && cpu_go;
`else
  assign cpu_first = 1'b0;
`endif

  assign cpu_start  = cpu_first || (cpu_go && !vdg_req && !vdg_pend_q);
  assign vdg_bypass = (state_q == S_IDLE) && vdg_req && !cpu_first;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      vdg_pend_q    <= 1'b0;
      vdg_addr_q    <= '0;
      vdg_data_q    <= '0;
      vdg_valid_q   <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_din_q     <= '0;
      vdg_overrun_q <= 1'b0;
`ifdef VRAM_CPU_FAIR_EN
      cpu_turn_q    <= 1'b0;
`endif
    end else begin
      vdg_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ram_we_q    <= 1'b0;

      // Any fetch request that cannot go straight to the RAM is parked; latest address wins.
      if (vdg_req && !vdg_bypass) begin
        vdg_pend_q <= 1'b1;
        vdg_addr_q <= vdg_addr;
        if (vdg_pend_q) vdg_overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
`ifdef VRAM_CPU_FAIR_EN
          cpu_turn_q <= 1'b0;
`endif
          if (cpu_start) begin
            ram_addr_q <= cpu_addr;
            if (cpu_we) begin
              ram_we_q  <= 1'b1;
              ram_din_q <= cpu_wdata;
              state_q   <= S_CWR;
            end else begin
              state_q   <= S_CRD;
            end
          end else if (vdg_req) begin
            ram_addr_q <= vdg_addr;
            vdg_pend_q <= 1'b0;
            if (vdg_pend_q) vdg_overrun_q <= 1'b1;
            state_q    <= S_VRD;
          end else if (vdg_pend_q) begin
            ram_addr_q <= vdg_addr_q;
            vdg_pend_q <= 1'b0;
            state_q    <= S_VRD;
          end
        end
        S_VRD: state_q <= S_VCAP;
        S_VCAP: begin
          vdg_data_q  <= ram_dout;
          vdg_valid_q <= 1'b1;
`ifdef VRAM_CPU_FAIR_EN
          cpu_turn_q  <= cpu_req;
`endif
          state_q     <= S_IDLE;
        end
        S_CRD: state_q <= S_CCAP;
        S_CCAP: begin
          cpu_rdata_q <= ram_dout;
          cpu_ack_q   <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_CWR: begin
          cpu_ack_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vdg_data    = vdg_data_q;
  assign vdg_valid   = vdg_valid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_din     = ram_din_q;
  assign vdg_overrun = vdg_overrun_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdg_req = 1'b0;
  logic [12:0] vdg_addr = '0;
  logic [7:0]  vdg_data;
  logic        vdg_valid;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;
  logic        vdg_overrun;

  logic [7:0] mem [0:8191];

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int t0 = 0;
  int vv_at, ack_at, vv_cnt, ack_cnt, we_cnt, dbl_cnt;
  logic [7:0] vdata_seen, rdata_seen;
  logic prev_vv = 1'b0, prev_ack = 1'b0;

  vram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_data(vdg_data), .vdg_valid(vdg_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .vdg_overrun(vdg_overrun)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, 1-clock read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) edge_n = edge_n + 1;

  always @(negedge clk) begin
    if (vdg_valid) begin
      vv_cnt = vv_cnt + 1;
      if (vv_at < 0) vv_at = edge_n - t0;
      vdata_seen = vdg_data;
    end
    if (cpu_ack) begin
      ack_cnt = ack_cnt + 1;
      if (ack_at < 0) ack_at = edge_n - t0;
      rdata_seen = cpu_rdata;
    end
    if (ram_we) we_cnt = we_cnt + 1;
    if ((vdg_valid && prev_vv) || (cpu_ack && prev_ack)) dbl_cnt = dbl_cnt + 1;
    prev_vv  = vdg_valid;
    prev_ack = cpu_ack;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic mon_clear();
    vv_at = -1; ack_at = -1; vv_cnt = 0; ack_cnt = 0; we_cnt = 0; dbl_cnt = 0;
    vdata_seen = '0; rdata_seen = '0;
    t0 = edge_n + 1;
  endtask

  task automatic cpu_set(input logic we, input logic [12:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic wait_ack(input int budget, input bit hold_extra);
    int n = 0;
    while (!cpu_ack && n < budget) begin
      step();
      n++;
    end
    check_eq("ack_seen", 32'(cpu_ack), 32'd1);
    if (hold_extra) step();
    cpu_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'h5A;
    mem[13'h0010] = 8'h3C;
    mem[13'h0100] = 8'h11;
    mem[13'h0200] = 8'h22;
    mon_clear();

    // Reset state
    settle(3);
    check_eq("rst_vdg_valid", 32'(vdg_valid), 0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 0);
    check_eq("rst_ram_we", 32'(ram_we), 0);
    check_eq("rst_vdg_data", 32'(vdg_data), 0);
    check_eq("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check_eq("rst_ram_addr", 32'(ram_addr), 0);
    check_eq("rst_ram_din", 32'(ram_din), 0);
    check_eq("rst_overrun", 32'(vdg_overrun), 0);
    reset_n = 1'b1;
    settle(2);

    // Uncontended VDG fetch
    mon_clear();
    vdg_req = 1'b1; vdg_addr = 13'h0123;
    step();
    vdg_req = 1'b0;
    check_eq("vrd_ram_addr", 32'(ram_addr), 32'h0123);
    check_eq("vrd_ram_we", 32'(ram_we), 0);
    settle(4);
    check_eq("v_latency", 32'(vv_at), 2);
    check_eq("v_data", 32'(vdata_seen), 32'h5A);
    check_eq("v_count", 32'(vv_cnt), 1);
    check_eq("v_no_ack", 32'(ack_cnt), 0);

    // Second request while first fetch is in VRD: follow-up, no overrun
    mon_clear();
    vdg_req = 1'b1; vdg_addr = 13'h0123;
    step();
    vdg_addr = 13'h0010;
    step();
    vdg_req = 1'b0;
    settle(8);
    check_eq("follow_count", 32'(vv_cnt), 2);
    check_eq("follow_data", 32'(vdata_seen), 32'h3C);
    check_eq("follow_no_ovr", 32'(vdg_overrun), 0);
    check_eq("follow_no_dbl", 32'(dbl_cnt), 0);

    // CPU write to top address
    mon_clear();
    cpu_set(1'b1, 13'h1FFF, 8'hA5);
    step();
    check_eq("cwr_ram_we", 32'(ram_we), 1);
    check_eq("cwr_ram_addr", 32'(ram_addr), 32'h1FFF);
    check_eq("cwr_ram_din", 32'(ram_din), 32'hA5);
    wait_ack(4, 1'b0);
    settle(3);
    check_eq("cwr_latency", 32'(ack_at), 1);
    check_eq("cwr_we_cycles", 32'(we_cnt), 1);
    check_eq("cwr_din_hold", 32'(ram_din), 32'hA5);
    check_eq("cwr_ack_count", 32'(ack_cnt), 1);

    // CPU read back, request held through the ack cycle
    mon_clear();
    cpu_set(1'b0, 13'h1FFF, 8'h00);
    wait_ack(6, 1'b1);
    settle(4);
    check_eq("crd_latency", 32'(ack_at), 2);
    check_eq("crd_data", 32'(rdata_seen), 32'hA5);
    check_eq("crd_single_ack", 32'(ack_cnt), 1);
    check_eq("crd_no_we", 32'(we_cnt), 0);

    // Simultaneous VDG and CPU requests: VDG first
    mon_clear();
    vdg_req = 1'b1; vdg_addr = 13'h0123;
    cpu_set(1'b0, 13'h0010, 8'h00);
    step();
    vdg_req = 1'b0;
    wait_ack(10, 1'b0);
    settle(2);
    check_eq("both_v_latency", 32'(vv_at), 2);
    check_eq("both_ack_latency", 32'(ack_at), 5);
    check_eq("both_v_data", 32'(vdata_seen), 32'h5A);
    check_eq("both_rdata", 32'(rdata_seen), 32'h3C);

    // Two VDG requests during a CPU read: latest wins, overrun set
    mon_clear();
    cpu_set(1'b0, 13'h0010, 8'h00);
    step();
    vdg_req = 1'b1; vdg_addr = 13'h0100;
    step();
    vdg_addr = 13'h0200;
    step();
    vdg_req = 1'b0;
    check_eq("ovr_cpu_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    check_eq("ovr_flag", 32'(vdg_overrun), 1);
    settle(6);
    check_eq("ovr_fetch_count", 32'(vv_cnt), 1);
    check_eq("ovr_fetch_data", 32'(vdata_seen), 32'h22);
    check_eq("ovr_fetch_latency", 32'(vv_at), 5);

    // Continuous VDG stream starves a held CPU request under strict priority
    mon_clear();
    cpu_set(1'b0, 13'h0010, 8'h00);
    for (int i = 0; i < 12; i++) begin
      vdg_req = 1'b1; vdg_addr = 13'h0123;
      step();
      vdg_req = 1'b0;
      step();
    end
`ifdef VRAM_CPU_FAIR_EN
    check_eq("stream_fair_ack", 32'(ack_cnt > 0), 1);
`else
    check_eq("stream_starved", 32'(ack_cnt), 0);
`endif
    check_eq("stream_fetches", 32'(vv_cnt > 0), 1);
    if (ack_cnt == 0) wait_ack(20, 1'b0);
    cpu_req = 1'b0;
    settle(2);
    check_eq("stream_rdata", 32'(rdata_seen), 32'h3C);
    check_eq("ovr_sticky", 32'(vdg_overrun), 1);
    check_eq("no_double_pulse", 32'(dbl_cnt), 0);

    // Reset during CWR
    mon_clear();
    cpu_set(1'b1, 13'h0555, 8'h77);
    step();
    check_eq("cwr2_ram_we", 32'(ram_we), 1);
    reset_n = 1'b0;
    step();
    cpu_req = 1'b0;
    check_eq("rcwr_ack", 32'(cpu_ack), 0);
    check_eq("rcwr_ram_we", 32'(ram_we), 0);
    check_eq("rcwr_ram_addr", 32'(ram_addr), 0);
    check_eq("rcwr_ram_din", 32'(ram_din), 0);
    check_eq("rcwr_overrun", 32'(vdg_overrun), 0);
    check_eq("rcwr_vdg_data", 32'(vdg_data), 0);
    step();
    reset_n = 1'b1;
    step();

    // Reset during CCAP
    mon_clear();
    cpu_set(1'b0, 13'h0010, 8'h00);
    settle(2);
    reset_n = 1'b0;
    step();
    cpu_req = 1'b0;
    check_eq("rccap_ack", 32'(cpu_ack), 0);
    check_eq("rccap_rdata", 32'(cpu_rdata), 0);
    check_eq("rccap_ram_addr", 32'(ram_addr), 0);
    reset_n = 1'b1;
    settle(4);
    check_eq("rccap_no_ack", 32'(ack_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
